// File: rtl/cpu_pkg.sv
// Shared moxie CPU constants and the scoreboard FSM state encoding.
// Used by the register file, decode, execute and the scoreboard.
package cpu_pkg;

  localparam int NREGS = 16;
  localparam int IDX_W = 4;

  typedef logic [1:0] sb_state_t;

  localparam sb_state_t SB_RUN    = 2'd0;
  localparam sb_state_t SB_DRAIN  = 2'd1;
  localparam sb_state_t SB_HALTED = 2'd2;

endpackage

// File: rtl/cpu_scoreboard.sv
// Register scoreboard and issue controller: tracks in-flight writes, stalls
// decode on RAW/WAW hazards and drains the pipeline on request.
//
// state  | meaning
// RUN    | normal issue, stalls only on register conflicts
// DRAIN  | all issue stalled, waiting for in-flight writes to retire
// HALTED | pipeline empty, drain_ack_o high, issue still stalled
module cpu_scoreboard
  import cpu_pkg::*;
#(
  parameter int NREGS = cpu_pkg::NREGS,
  parameter int IDX_W = cpu_pkg::IDX_W,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             issue_valid_i,
  input  logic             rd_en_a_i,
  input  logic [IDX_W-1:0] rd_idx_a_i,
  input  logic             rd_en_b_i,
  input  logic [IDX_W-1:0] rd_idx_b_i,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wb_en_i,
  input  logic [IDX_W-1:0] wb_idx_i,
  input  logic             flush_i,
  input  logic             drain_req_i,
  output logic             stall_o,
  output logic             issue_o,
  output logic             drain_ack_o,
  output logic [NREGS-1:0] busy_o,
  output logic [IDX_W:0]   outstanding_o,
  output logic [CNT_W-1:0] stall_count_o
);

  function automatic logic [IDX_W:0] popcount(input logic [NREGS-1:0] v);
    logic [IDX_W:0] c;
    c = '0;
    for (int i = 0; i < NREGS; i++) begin
      c = c + {{IDX_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  sb_state_t        state_q, state_next;
  logic [NREGS-1:0] busy_q, busy_next;
  logic [IDX_W:0]   outstanding_q;
  logic [CNT_W-1:0] stall_count_q;
  logic             drain_ack_q;
  logic             conflict;

  // Hazards are judged against registered busy bits only; no writeback bypass.
  assign conflict = (rd_en_a_i & busy_q[rd_idx_a_i])
                  | (rd_en_b_i & busy_q[rd_idx_b_i])
                  | (wr_en_i   & busy_q[wr_idx_i]);

  assign stall_o = issue_valid_i & ((state_q != SB_RUN) | conflict);
  assign issue_o = issue_valid_i & ~stall_o & ~flush_i;

  always_comb begin
    busy_next = busy_q;
    if (flush_i) begin
      busy_next = '0;
    end else begin
      if (wb_en_i)
        busy_next[wb_idx_i] = 1'b0;
      if (issue_o && wr_en_i)
        busy_next[wr_idx_i] = 1'b1;
    end
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      SB_RUN: begin
        if (drain_req_i)
          state_next = SB_DRAIN;
      end
      SB_DRAIN: begin
        if (!drain_req_i)
          state_next = SB_RUN;
        else if (busy_q == '0)
          state_next = SB_HALTED;
      end
      SB_HALTED: begin
        if (!drain_req_i)
          state_next = SB_RUN;
      end
      default: state_next = SB_RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= SB_RUN;
      busy_q        <= '0;
      outstanding_q <= '0;
      stall_count_q <= '0;
      drain_ack_q   <= 1'b0;
    end else begin
      state_q       <= state_next;
      busy_q        <= busy_next;
      outstanding_q <= popcount(busy_next);
      drain_ack_q   <= (state_next == SB_HALTED);
      if (stall_o && (stall_count_q != {CNT_W{1'b1}}))
        stall_count_q <= stall_count_q + CNT_W'(1);
    end
  end

  assign busy_o        = busy_q;
  assign outstanding_o = outstanding_q;
  assign stall_count_o = stall_count_q;
  assign drain_ack_o   = drain_ack_q;

endmodule

// File: tb/tb_cpu_scoreboard.sv
// Self-checking bench for cpu_scoreboard: vector table with a queue of expected
// registered results, plus hand sequences for saturation and reset mid-drain.
module tb_cpu_scoreboard;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        issue_valid_i, rd_en_a_i, rd_en_b_i, wr_en_i, wb_en_i, flush_i, drain_req_i;
  logic [3:0]  rd_idx_a_i, rd_idx_b_i, wr_idx_i, wb_idx_i;
  logic        stall_o, issue_o, drain_ack_o;
  logic [15:0] busy_o;
  logic [4:0]  outstanding_o;
  logic [15:0] stall_count_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_scoreboard dut (
    .clk_i(clk), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i),
    .rd_en_a_i(rd_en_a_i), .rd_idx_a_i(rd_idx_a_i),
    .rd_en_b_i(rd_en_b_i), .rd_idx_b_i(rd_idx_b_i),
    .wr_en_i(wr_en_i), .wr_idx_i(wr_idx_i),
    .wb_en_i(wb_en_i), .wb_idx_i(wb_idx_i),
    .flush_i(flush_i), .drain_req_i(drain_req_i),
    .stall_o(stall_o), .issue_o(issue_o), .drain_ack_o(drain_ack_o),
    .busy_o(busy_o), .outstanding_o(outstanding_o), .stall_count_o(stall_count_o)
  );

  typedef struct {
    logic iv; logic ea; logic [3:0] ia; logic eb; logic [3:0] ib;
    logic we; logic [3:0] wi; logic wbe; logic [3:0] wbi; logic fl; logic dr;
    logic stall; logic issue; logic [15:0] busy; logic [4:0] outst; logic ack;
  } vec_t;

  typedef struct {
    logic [15:0] busy; logic [4:0] outst; logic ack; logic [15:0] scnt;
  } exp_t;

  vec_t        vecs[$];
  exp_t        exp_q[$];
  logic [15:0] scnt_model = 16'h0;

  function automatic vec_t mk(input logic iv, input logic ea, input logic [3:0] ia,
                              input logic eb, input logic [3:0] ib,
                              input logic we, input logic [3:0] wi,
                              input logic wbe, input logic [3:0] wbi,
                              input logic fl, input logic dr,
                              input logic stall, input logic issue,
                              input logic [15:0] busy, input logic [4:0] outst,
                              input logic ack);
    vec_t v;
    v.iv = iv; v.ea = ea; v.ia = ia; v.eb = eb; v.ib = ib;
    v.we = we; v.wi = wi; v.wbe = wbe; v.wbi = wbi; v.fl = fl; v.dr = dr;
    v.stall = stall; v.issue = issue; v.busy = busy; v.outst = outst; v.ack = ack;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    issue_valid_i = 0; rd_en_a_i = 0; rd_idx_a_i = 0; rd_en_b_i = 0; rd_idx_b_i = 0;
    wr_en_i = 0; wr_idx_i = 0; wb_en_i = 0; wb_idx_i = 0; flush_i = 0; drain_req_i = 0;
  endtask

  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    @(negedge clk);
    issue_valid_i = v.iv; rd_en_a_i = v.ea; rd_idx_a_i = v.ia; rd_en_b_i = v.eb;
    rd_idx_b_i = v.ib; wr_en_i = v.we; wr_idx_i = v.wi; wb_en_i = v.wbe;
    wb_idx_i = v.wbi; flush_i = v.fl; drain_req_i = v.dr;
    #1;
    chk({tag, " stall"}, stall_o, v.stall);
    chk({tag, " issue"}, issue_o, v.issue);
    if (v.stall && scnt_model != 16'hFFFF) scnt_model = scnt_model + 16'd1;
    e.busy = v.busy; e.outst = v.outst; e.ack = v.ack; e.scnt = scnt_model;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, " busy"}, busy_o, e.busy);
    chk({tag, " outstanding"}, outstanding_o, e.outst);
    chk({tag, " drain_ack"}, drain_ack_o, e.ack);
    chk({tag, " stall_count"}, stall_count_o, e.scnt);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] acc;
    rst_i = 1'b1;
    drive_idle();

    // ldi r3 then dec r3: stalls until r3 writeback, issues the cycle after
    vecs.push_back(mk(1,0,0, 0,0, 1,3, 0,0, 0,0, 0,1, 16'h0008,1,0));
    vecs.push_back(mk(1,1,3, 0,0, 1,3, 0,0, 0,0, 1,0, 16'h0008,1,0));
    vecs.push_back(mk(1,1,3, 0,0, 1,3, 0,0, 0,0, 1,0, 16'h0008,1,0));
    vecs.push_back(mk(1,1,3, 0,0, 1,3, 1,3, 0,0, 1,0, 16'h0000,0,0));
    vecs.push_back(mk(1,1,3, 0,0, 1,3, 0,0, 0,0, 0,1, 16'h0008,1,0));
    vecs.push_back(mk(0,0,0, 0,0, 0,0, 1,3, 0,0, 0,0, 16'h0000,0,0));
    // r1, r2, r5 in flight, then retired 2, 1, 5
    vecs.push_back(mk(1,0,0, 0,0, 1,1, 0,0, 0,0, 0,1, 16'h0002,1,0));
    vecs.push_back(mk(1,0,0, 0,0, 1,2, 0,0, 0,0, 0,1, 16'h0006,2,0));
    vecs.push_back(mk(1,0,0, 0,0, 1,5, 0,0, 0,0, 0,1, 16'h0026,3,0));
    vecs.push_back(mk(0,0,0, 0,0, 0,0, 1,2, 0,0, 0,0, 16'h0022,2,0));
    vecs.push_back(mk(0,0,0, 0,0, 0,0, 1,1, 0,0, 0,0, 16'h0020,1,0));
    vecs.push_back(mk(0,0,0, 0,0, 0,0, 1,5, 0,0, 0,0, 16'h0000,0,0));
    // spurious writeback, WAW stall, same-cycle writeback is not bypassed
    vecs.push_back(mk(1,0,0, 0,0, 1,4, 0,0, 0,0, 0,1, 16'h0010,1,0));
    vecs.push_back(mk(0,0,0, 0,0, 0,0, 1,7, 0,0, 0,0, 16'h0010,1,0));
    vecs.push_back(mk(1,0,0, 0,0, 1,4, 0,0, 0,0, 1,0, 16'h0010,1,0));
    vecs.push_back(mk(1,1,4, 0,0, 0,0, 1,4, 0,0, 1,0, 16'h0000,0,0));
    vecs.push_back(mk(1,1,4, 0,0, 0,0, 0,0, 0,0, 0,1, 16'h0000,0,0));
    // source B conflicts; disabled enables ignore busy indices
    vecs.push_back(mk(1,0,0, 0,0, 1,6, 0,0, 0,0, 0,1, 16'h0040,1,0));
    vecs.push_back(mk(1,0,6, 0,6, 0,6, 0,0, 0,0, 0,1, 16'h0040,1,0));
    vecs.push_back(mk(1,0,0, 1,6, 0,0, 0,0, 0,0, 1,0, 16'h0040,1,0));
    vecs.push_back(mk(1,0,0, 1,6, 0,0, 1,6, 0,0, 1,0, 16'h0000,0,0));
    vecs.push_back(mk(1,0,0, 1,6, 0,0, 0,0, 0,0, 0,1, 16'h0000,0,0));
    // drain with r2 busy, ack after retirement, release resumes issue
    vecs.push_back(mk(1,0,0, 0,0, 1,2, 0,0, 0,0, 0,1, 16'h0004,1,0));
    vecs.push_back(mk(0,0,0, 0,0, 0,0, 0,0, 0,1, 0,0, 16'h0004,1,0));
    vecs.push_back(mk(1,0,0, 0,0, 1,9, 0,0, 0,1, 1,0, 16'h0004,1,0));
    vecs.push_back(mk(1,0,0, 0,0, 0,0, 1,2, 0,1, 1,0, 16'h0000,0,0));
    vecs.push_back(mk(1,0,0, 0,0, 0,0, 0,0, 0,1, 1,0, 16'h0000,0,1));
    vecs.push_back(mk(1,0,0, 0,0, 0,0, 0,0, 0,1, 1,0, 16'h0000,0,1));
    vecs.push_back(mk(1,0,0, 0,0, 0,0, 0,0, 0,0, 1,0, 16'h0000,0,0));
    vecs.push_back(mk(1,0,0, 0,0, 1,9, 0,0, 0,0, 0,1, 16'h0200,1,0));
    vecs.push_back(mk(0,0,0, 0,0, 0,0, 1,9, 0,0, 0,0, 16'h0000,0,0));
    // drain aborted before busy clears
    vecs.push_back(mk(1,0,0, 0,0, 1,10, 0,0, 0,0, 0,1, 16'h0400,1,0));
    vecs.push_back(mk(0,0,0, 0,0, 0,0, 0,0, 0,1, 0,0, 16'h0400,1,0));
    vecs.push_back(mk(1,0,0, 0,0, 0,0, 0,0, 0,1, 1,0, 16'h0400,1,0));
    vecs.push_back(mk(1,0,0, 0,0, 1,11, 0,0, 0,0, 1,0, 16'h0400,1,0));
    vecs.push_back(mk(1,0,0, 0,0, 1,11, 0,0, 0,0, 0,1, 16'h0C00,2,0));
    vecs.push_back(mk(0,0,0, 0,0, 0,0, 0,0, 1,0, 0,0, 16'h0000,0,0));
    // fill r0..r7, r0 is tracked like any other register, flush kills a clean issue
    acc = 16'h0;
    for (int r = 0; r < 8; r++) begin
      acc[r] = 1'b1;
      vecs.push_back(mk(1,0,0, 0,0, 1,4'(r), 0,0, 0,0, 0,1, acc,5'(r + 1),0));
    end
    vecs.push_back(mk(1,1,0, 0,0, 0,0, 0,0, 0,0, 1,0, 16'h00FF,8,0));
    vecs.push_back(mk(1,0,0, 0,0, 1,9, 0,0, 1,0, 0,0, 16'h0000,0,0));
    vecs.push_back(mk(1,1,0, 0,0, 0,0, 0,0, 0,0, 0,1, 16'h0000,0,0));
    // flush during drain, then drain with nothing in flight
    vecs.push_back(mk(1,0,0, 0,0, 1,3, 0,0, 0,0, 0,1, 16'h0008,1,0));
    vecs.push_back(mk(0,0,0, 0,0, 0,0, 0,0, 0,1, 0,0, 16'h0008,1,0));
    vecs.push_back(mk(0,0,0, 0,0, 0,0, 0,0, 1,1, 0,0, 16'h0000,0,0));
    vecs.push_back(mk(0,0,0, 0,0, 0,0, 0,0, 0,1, 0,0, 16'h0000,0,1));
    vecs.push_back(mk(0,0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 16'h0000,0,0));
    vecs.push_back(mk(0,0,0, 0,0, 0,0, 0,0, 0,1, 0,0, 16'h0000,0,0));
    vecs.push_back(mk(0,0,0, 0,0, 0,0, 0,0, 0,1, 0,0, 16'h0000,0,1));
    vecs.push_back(mk(0,0,0, 0,0, 0,0, 0,0, 0,0, 0,0, 16'h0000,0,0));

    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", busy_o, 16'h0);
    chk("reset outstanding", outstanding_o, 5'h0);
    chk("reset stall_count", stall_count_o, 16'h0);
    chk("reset drain_ack", drain_ack_o, 1'b0);
    @(negedge clk);
    rst_i = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("v%0d", i));
    end

    // hold a RAW stall long enough to saturate the statistics counter
    @(negedge clk);
    drive_idle();
    issue_valid_i = 1; wr_en_i = 1; wr_idx_i = 1;
    #1;
    chk("sat setup issue", issue_o, 1'b1);
    @(negedge clk);
    wr_en_i = 0; rd_en_a_i = 1; rd_idx_a_i = 1;
    #1;
    chk("sat stall", stall_o, 1'b1);
    while (scnt_model != 16'hFFFE) begin
      @(posedge clk);
      scnt_model = scnt_model + 16'd1;
    end
    #1;
    chk("sat count FFFE", stall_count_o, 16'hFFFE);
    @(posedge clk);
    #1;
    chk("sat count FFFF", stall_count_o, 16'hFFFF);
    repeat (5) @(posedge clk);
    #1;
    chk("sat count held", stall_count_o, 16'hFFFF);

    // reset in the middle of a drain overrides all other inputs
    @(negedge clk);
    drain_req_i = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("pre-reset busy", busy_o, 16'h0002);
    chk("pre-reset drain_ack", drain_ack_o, 1'b0);
    @(negedge clk);
    rst_i = 1; wr_en_i = 1; wr_idx_i = 2; flush_i = 0;
    @(posedge clk);
    #1;
    chk("rst busy", busy_o, 16'h0);
    chk("rst outstanding", outstanding_o, 5'h0);
    chk("rst stall_count", stall_count_o, 16'h0);
    chk("rst drain_ack", drain_ack_o, 1'b0);
    @(negedge clk);
    drive_idle();
    rst_i = 0; issue_valid_i = 1; wr_en_i = 1; wr_idx_i = 5;
    #1;
    chk("post-rst stall", stall_o, 1'b0);
    chk("post-rst issue", issue_o, 1'b1);
    @(posedge clk);
    #1;
    chk("post-rst busy", busy_o, 16'h0020);
    chk("post-rst outstanding", outstanding_o, 5'h1);
    @(negedge clk);
    drive_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
